// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_sequencer
//  Description : Sequencing controller for the KGP-RISC branch unit.
//                Owns the PC and the architectural flag register, fetches
//                instructions over a req/valid handshake, holds each
//                instruction until the datapath reports completion, then
//                commits pc+4 or the branch target. Generates the
//                return-address write strobe for calls and parks on halt.
//                Optional feature macro: BRANCH_COUNT_EN adds a saturating
//                taken-branch counter on output taken_count.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_sequencer #(
    parameter int              PC_W        = 12,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              HALT_OPCODE = 63,
    parameter int              CALL_OPCODE = 58
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic            flag_we,
    input  logic [3:0]      alu_flags,
    output logic            carry_flag,
    output logic            zero_flag,
    output logic            sign_flag,
    output logic            overflow_flag,
    input  logic            is_branch,
    input  logic [PC_W-1:0] pc_label,
    output logic [PC_W-1:0] pc,
    output logic            ra_we,
    output logic            halted
`ifdef BRANCH_COUNT_EN
    ,
    output logic [15:0]     taken_count
`endif
);

    localparam logic [5:0]      c_HALT_OP = 6'(HALT_OPCODE);
    localparam logic [5:0]      c_CALL_OP = 6'(CALL_OPCODE);
    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [3:0]      r_flags;
    logic            r_imemReq;
    logic            r_instrValid;
    logic            r_halted;

    logic            w_execDone;
    logic            w_isHalt;
    logic            w_isCall;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_nextPc;
    logic            w_unusedLabelBits;

    // Completion is only meaningful while an instruction is being executed
    assign w_execDone = (r_state == S_EXEC) && exec_done;
    assign w_isHalt   = (r_instr[31:26] == c_HALT_OP);
    assign w_isCall   = (r_instr[31:26] == c_CALL_OP);

    // Branch targets are word aligned; the label's low bits are discarded
    assign w_target          = {pc_label[PC_W-1:2], 2'b00};
    assign w_unusedLabelBits = ^pc_label[1:0];
    assign w_nextPc          = is_branch ? w_target : (r_pc + c_PC_STEP);

    // Sequencer: state, PC, instruction latch, flags and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_flags      <= '0;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state   <= S_FETCH;
                    r_imemReq <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        r_instr      <= imem_data;
                        r_state      <= S_EXEC;
                        r_imemReq    <= 1'b0;
                        r_instrValid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        // New flags are seen by the next instruction only
                        if (flag_we) begin
                            r_flags <= alu_flags;
                        end
                        r_instrValid <= 1'b0;
                        if (w_isHalt) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc      <= w_nextPc;
                            r_state   <= S_FETCH;
                            r_imemReq <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state      <= S_BOOT;
                    r_imemReq    <= 1'b0;
                    r_instrValid <= 1'b0;
                    r_halted     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [15:0] r_takenCount;

    // Saturating count of completed instructions whose branch was taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_takenCount <= '0;
        end else if (w_execDone && is_branch && (r_takenCount != 16'hFFFF)) begin
            r_takenCount <= r_takenCount + 16'd1;
        end
    end

    assign taken_count = r_takenCount;
`endif

    // Return-address write happens in the completion cycle so the register
    // file captures a value derived from the still-current PC
    assign ra_we = w_execDone && w_isCall;

    assign imem_req      = r_imemReq;
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = r_instrValid;
    assign halted        = r_halted;
    assign carry_flag    = r_flags[3];
    assign zero_flag     = r_flags[2];
    assign sign_flag     = r_flags[1];
    assign overflow_flag = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_sequencer
//  Description : Self-checking bench for branch_sequencer. Directed scenarios
//                followed by randomized traffic, compared every cycle against
//                an instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        flag_we = 1'b0;
    logic [3:0]  alu_flags = '0;
    logic        carry_flag, zero_flag, sign_flag, overflow_flag;
    logic        is_branch = 1'b0;
    logic [11:0] pc_label = '0;
    logic [11:0] pc;
    logic        ra_we;
    logic        halted;
`ifdef BRANCH_COUNT_EN
    logic [15:0] taken_count;
`endif

    branch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .flag_we      (flag_we),
        .alu_flags    (alu_flags),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .sign_flag    (sign_flag),
        .overflow_flag(overflow_flag),
        .is_branch    (is_branch),
        .pc_label     (pc_label),
        .pc           (pc),
        .ra_we        (ra_we),
        .halted       (halted)
`ifdef BRANCH_COUNT_EN
        ,
        .taken_count  (taken_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Reference model: what the sequencer is doing, at instruction level
    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;
    int          mMode;
    int          mPc;
    logic [31:0] mInstr;
    logic [3:0]  mFlags;
    int          mCount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode  = M_BOOT;
        mPc    = 0;
        mInstr = '0;
        mFlags = '0;
        mCount = 0;
    endtask

    task automatic modelStep();
        if (rst) begin
            modelReset();
        end else if (mMode == M_BOOT) begin
            mMode = M_FETCH;
        end else if (mMode == M_FETCH) begin
            if (imem_valid) begin
                mInstr = imem_data;
                mMode  = M_EXEC;
            end
        end else if (mMode == M_EXEC && exec_done) begin
            if (is_branch && mCount < 65535) mCount = mCount + 1;
            if (flag_we) mFlags = alu_flags;
            if (mInstr[31:26] == 6'd63) begin
                mMode = M_HALT;
            end else begin
                if (is_branch) mPc = int'(pc_label) - (int'(pc_label) % 4);
                else           mPc = (mPc + 4) % 4096;
                mMode = M_FETCH;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checkEn) begin
            check("pc", 32'(pc), 32'(mPc));
            check("imem_addr", 32'(imem_addr), 32'(mPc));
            check("imem_req", 32'(imem_req), 32'(mMode == M_FETCH));
            check("instr_valid", 32'(instr_valid), 32'(mMode == M_EXEC));
            check("halted", 32'(halted), 32'(mMode == M_HALT));
            check("instr", instr, mInstr);
            check("flags", 32'({carry_flag, zero_flag, sign_flag, overflow_flag}), 32'(mFlags));
            check("ra_we", 32'(ra_we),
                  32'(mMode == M_EXEC && exec_done && mInstr[31:26] == 6'd58));
`ifdef BRANCH_COUNT_EN
            check("taken_count", 32'(taken_count), 32'(mCount));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        modelStep();
        #2;
    endtask

    // Issue one instruction starting from FETCH; completion in the first EXEC cycle
    task automatic runInstr(input logic [5:0] op, input logic br, input logic [11:0] lbl,
                            input logic fwe, input logic [3:0] fl);
        logic [31:0] word;
        word       = {op, 26'($urandom)};
        imem_valid = 1'b1;
        imem_data  = word;
        exec_done  = 1'b0;
        tick();
        check("lit_instr_latched", instr, word);
        imem_valid = 1'b0;
        exec_done  = 1'b1;
        is_branch  = br;
        pc_label   = lbl;
        flag_we    = fwe;
        alu_flags  = fl;
        #1;
        check("lit_ra_we_pulse", 32'(ra_we), 32'(op == 6'd58));
        tick();
        exec_done = 1'b0;
        is_branch = 1'b0;
        flag_we   = 1'b0;
        #1;
        check("lit_ra_we_clear", 32'(ra_we), 32'd0);
    endtask

    initial begin
        modelReset();
        tick();
        checkEn = 1'b1;
        // Reset state
        check("lit_rst_pc", 32'(pc), 32'h0);
        check("lit_rst_req", 32'(imem_req), 32'd0);
        check("lit_rst_ivalid", 32'(instr_valid), 32'd0);
        check("lit_rst_halted", 32'(halted), 32'd0);
        check("lit_rst_flags", 32'({carry_flag, zero_flag, sign_flag, overflow_flag}), 32'd0);

        // Release reset: one BOOT cycle then FETCH at 0
        rst = 1'b0;
        tick();
        check("lit_boot_req", 32'(imem_req), 32'd1);
        check("lit_addr0", 32'(imem_addr), 32'h000);

        // Sequential flow
        runInstr(6'd1, 1'b0, 12'h0, 1'b0, 4'h0);
        check("lit_addr4", 32'(imem_addr), 32'h004);
        check("lit_ivalid_low", 32'(instr_valid), 32'd0);
        runInstr(6'd2, 1'b0, 12'h0, 1'b0, 4'h0);
        check("lit_addr8", 32'(imem_addr), 32'h008);
        runInstr(6'd3, 1'b0, 12'h0, 1'b0, 4'h0);
        runInstr(6'd4, 1'b0, 12'h0, 1'b0, 4'h0);
        check("lit_addr10", 32'(pc), 32'h010);

        // Taken branch with unaligned label, then not-taken
        runInstr(6'd5, 1'b1, 12'h123, 1'b0, 4'h0);
        check("lit_branch_target", 32'(imem_addr), 32'h120);
        runInstr(6'd6, 1'b0, 12'h555, 1'b0, 4'h0);
        check("lit_not_taken", 32'(imem_addr), 32'h124);

        // Flag load and hold
        runInstr(6'd7, 1'b0, 12'h0, 1'b1, 4'b0100);
        check("lit_zero_flag", 32'(zero_flag), 32'd1);
        runInstr(6'd8, 1'b0, 12'h0, 1'b0, 4'b1111);
        check("lit_flags_hold", 32'({carry_flag, zero_flag, sign_flag, overflow_flag}), 32'b0100);

        // Call at 0x040 branching to 0x200
        runInstr(6'd9, 1'b1, 12'h040, 1'b0, 4'h0);
        check("lit_pc40", 32'(pc), 32'h040);
        runInstr(6'd58, 1'b1, 12'h200, 1'b0, 4'h0);
        check("lit_call_target", 32'(pc), 32'h200);

        // Wrap-around
        runInstr(6'd10, 1'b1, 12'hFFE, 1'b0, 4'h0);
        check("lit_pcFFC", 32'(pc), 32'hFFC);
        runInstr(6'd11, 1'b0, 12'h0, 1'b0, 4'h0);
        check("lit_wrap", 32'(pc), 32'h000);

        // Fetch stall with spurious completions
        exec_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("lit_stall_req", 32'(imem_req), 32'd1);
            check("lit_stall_addr", 32'(imem_addr), 32'h000);
        end
        exec_done = 1'b0;
        runInstr(6'd12, 1'b0, 12'h0, 1'b0, 4'h0);
        check("lit_after_stall", 32'(pc), 32'h004);

        // Halt: PC frozen even with a taken branch
        runInstr(6'd63, 1'b1, 12'h300, 1'b0, 4'h0);
        check("lit_halted", 32'(halted), 32'd1);
        check("lit_halt_pc", 32'(pc), 32'h004);
`ifdef BRANCH_COUNT_EN
        check("lit_taken_count", 32'(taken_count), 32'd5);
`endif
        for (int i = 0; i < 20; i++) begin
            imem_valid = 1'($urandom);
            exec_done  = 1'($urandom);
            tick();
            check("lit_halt_req", 32'(imem_req), 32'd0);
        end
        imem_valid = 1'b0;
        exec_done  = 1'b0;

        // Reset recovery from HALT
        rst = 1'b1;
        modelReset();
        tick();
        rst = 1'b0;
        tick();
        check("lit_recover_pc", 32'(pc), 32'h000);
        check("lit_recover_req", 32'(imem_req), 32'd1);

        // Async reset in the middle of a completing call
        runInstr(6'd13, 1'b1, 12'h080, 1'b1, 4'b1010);
        imem_valid = 1'b1;
        imem_data  = {6'd58, 26'h0};
        tick();
        imem_valid = 1'b0;
        exec_done  = 1'b1;
        is_branch  = 1'b1;
        rst        = 1'b1;
        modelReset();
        #1;
        check("lit_async_pc", 32'(pc), 32'h000);
        check("lit_async_ivalid", 32'(instr_valid), 32'd0);
        check("lit_async_instr", instr, 32'h0);
        check("lit_async_flags", 32'({carry_flag, zero_flag, sign_flag, overflow_flag}), 32'd0);
        check("lit_async_ra_we", 32'(ra_we), 32'd0);
        check("lit_async_req", 32'(imem_req), 32'd0);
`ifdef BRANCH_COUNT_EN
        check("lit_async_count", 32'(taken_count), 32'd0);
`endif
        tick();
        rst       = 1'b0;
        exec_done = 1'b0;
        is_branch = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int sel;
            tick();
            if (rst) begin
                rst = 1'b0;
            end
            sel        = int'($urandom_range(0, 19));
            imem_valid = ($urandom_range(0, 3) != 0);
            imem_data  = $urandom;
            if (sel == 0)      imem_data[31:26] = 6'd63;
            else if (sel < 5)  imem_data[31:26] = 6'd58;
            exec_done  = 1'($urandom);
            is_branch  = 1'($urandom);
            pc_label   = 12'($urandom);
            flag_we    = 1'($urandom);
            alu_flags  = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                modelReset();
            end
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
